// File: rtl/ps2_defs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_defs (package)
//  Purpose  : Shared definitions for the PS/2 host transmitter: FSM state
//             encoding, keyboard command bytes and the parity helper.
//  Revision : 1.0  initial release
// ============================================================================
package ps2_defs;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_INHIBIT     = 3'd1,
        ST_REQ         = 3'd2,
        ST_SEND        = 3'd3,
        ST_ACK_RELEASE = 3'd4,
        ST_DONE        = 3'd5,
        ST_ERR         = 3'd6
    } ps2_tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RESP_ACK     = 8'hFA;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_line_filter
//  Purpose  : Conditions one raw PS/2 line: 2-flop synchronizer followed by a
//             debounce that accepts a new level only after FILTER_LEN
//             consecutive synchronized samples at that level.
//  Ports    : clk      system clock
//             rst_n    asynchronous active-low reset
//             i_line   raw pin level
//             o_level  filtered level (idles high)
//             o_fall   one-cycle pulse on a filtered 1 -> 0 transition
//  Revision : 1.0  initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int              CW         = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(FILTER_LEN - 1);

    logic          r_meta;
    logic          r_sync;
    logic          r_level;
    logic          r_fall;
    logic [CW-1:0] r_cnt;

    // Sync and filter reset to 1 so an idle bus does not look like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_fall <= 1'b0;
            if (r_sync == r_level) begin
                // Any sample agreeing with the current level restarts the run.
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_level <= r_sync;
                r_cnt   <= '0;
                r_fall  <= ~r_sync;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : PS/2 host-to-device transmitter. Runs the request-to-send
//             sequence, shifts one command byte plus odd parity and stop bit
//             out on device-generated clocks and checks the device ACK.
//  Ports    : clk           system clock
//             rst_n         asynchronous active-low reset
//             i_tx_start    one-cycle request, i_tx_data sampled with it
//             i_tx_data     command byte
//             i_ps2_clk     raw PS2_CLK pin level
//             i_ps2_dat     raw PS2_KBDAT pin level
//             o_ps2_clk_oe  1 = pull PS2_CLK low, 0 = release
//             o_ps2_dat_oe  1 = pull PS2_KBDAT low, 0 = release
//             o_tx_busy     transmission in progress
//             o_tx_done     one-cycle pulse on device ACK
//             o_tx_error    one-cycle pulse on NACK or timeout
//             o_tx_nack     with o_tx_error: 1 = NACK, 0 = timeout
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_defs::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_tx_error,
    output logic       o_tx_nack
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] C_INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] C_REQ_LAST = CW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t r_state;
    ps2_tx_state_t w_state_next;

    logic [9:0]    r_frame;     // {stop, parity, data[7:0]}, shifted LSB first
    logic [3:0]    r_bit_idx;   // falling edges seen in SEND
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tmo;
    logic          r_dat_drv;   // pull data low while in SEND
    logic          r_nack;

    logic w_clk_level;
    logic w_clk_fall;
    logic w_dat_level;
    logic w_dat_fall_unused;
    logic w_timeout;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (i_ps2_clk),
        .o_level (w_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_line  (i_ps2_dat),
        .o_level (w_dat_level),
        .o_fall  (w_dat_fall_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and outputs. All outputs decode the state register, so an
    // asynchronous reset releases both lines immediately.
    always_comb begin
        w_state_next = r_state;
        w_timeout    = (r_tmo == C_TMO_LAST);
        o_ps2_clk_oe = 1'b0;
        o_ps2_dat_oe = 1'b0;
        o_tx_busy    = 1'b1;
        o_tx_done    = 1'b0;
        o_tx_error   = 1'b0;
        o_tx_nack    = r_nack;

        case (r_state)
            ST_IDLE: begin
                o_tx_busy = 1'b0;
                if (i_tx_start) begin
                    w_state_next = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                o_ps2_clk_oe = 1'b1;
                if (r_cnt == C_INH_LAST) begin
                    w_state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                o_ps2_clk_oe = 1'b1;
                o_ps2_dat_oe = 1'b1;
                if (r_cnt == C_REQ_LAST) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                o_ps2_dat_oe = r_dat_drv;
                // Timeout wins over an edge arriving in the same cycle.
                if (w_timeout) begin
                    w_state_next = ST_ERR;
                end else if (w_clk_fall && (r_bit_idx == 4'd10)) begin
                    w_state_next = w_dat_level ? ST_ERR : ST_ACK_RELEASE;
                end
            end
            ST_ACK_RELEASE: begin
                if (w_timeout) begin
                    w_state_next = ST_ERR;
                end else if (w_clk_level && w_dat_level) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_tx_busy    = 1'b0;
                o_tx_done    = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_ERR: begin
                o_tx_busy    = 1'b0;
                o_tx_error   = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                o_tx_busy    = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame   <= '0;
            r_bit_idx <= '0;
            r_cnt     <= '0;
            r_tmo     <= '0;
            r_dat_drv <= 1'b0;
            r_nack    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dat_drv <= 1'b0;
                    r_cnt     <= '0;
                    if (i_tx_start) begin
                        r_frame <= {1'b1, odd_parity(i_tx_data), i_tx_data};
                        r_nack  <= 1'b0;
                    end
                end
                ST_INHIBIT: begin
                    r_cnt <= (r_cnt == C_INH_LAST) ? '0 : r_cnt + CW'(1);
                end
                ST_REQ: begin
                    r_cnt     <= r_cnt + CW'(1);
                    r_bit_idx <= '0;
                    r_tmo     <= '0;
                    // Start bit stays driven into SEND until the first edge.
                    r_dat_drv <= 1'b1;
                end
                ST_SEND: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (!w_timeout && w_clk_fall) begin
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx <= 4'd9) begin
                            r_dat_drv <= ~r_frame[r_bit_idx];
                        end else begin
                            r_dat_drv <= 1'b0;
                            r_nack    <= w_dat_level;
                        end
                    end
                end
                ST_ACK_RELEASE: begin
                    r_tmo     <= r_tmo + TW'(1);
                    r_dat_drv <= 1'b0;
                end
                default: begin
                    r_dat_drv <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
